// File: rtl/copy_array_partition_param.sv
`default_nettype none
// copy_array_partition_param: stable partition copy of M into N, chunk-2 elements first.
// Revision 1.0 - parametrised successor to the 4-bit ten-element copier.
module copy_array_partition_param #(
   parameter int DW    = 4,
   parameter int DEPTH = 10,
   parameter int AW    = 4
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic          Ack,
   input  logic          Mode,
   input  logic [DW-1:0] Ms_of_I,
   output logic [AW-1:0] I,
   output logic [AW-1:0] J,
   output logic          Ns_of_J_Write,
   output logic [AW:0]   Split,
   output logic          Done,
   output logic          Qi,
   output logic          Qls,
   output logic          Qcb,
   output logic          Qd
);

   typedef enum logic [3:0] {
      INI  = 4'b0001,
      LS2C = 4'b0010,
      CBC  = 4'b0100,
      DONE = 4'b1000
   } state_t;

   localparam logic [AW-1:0] LAST      = AW'(DEPTH - 1);
   localparam logic [AW-1:0] IDX_ONE   = AW'(1);
   localparam logic [AW:0]   SPLIT_ONE = (AW + 1)'(1);

   state_t          state_q, state_d;
   logic [AW-1:0]   i_q, i_d;
   logic [AW-1:0]   j_q, j_d;
   logic [AW:0]     split_q, split_d;
   logic            mode_q, mode_d;
   logic            c2;

   // Mode_r flips which MSB value belongs to the first group.
   assign c2 = Ms_of_I[DW-1] ^ mode_q;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= INI;
         i_q     <= '0;
         j_q     <= '0;
         split_q <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         split_q <= split_d;
         mode_q  <= mode_d;
      end
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      split_d = split_q;
      mode_d  = mode_q;
      case (state_q)
         INI: begin
            i_d = '0;
            j_d = '0;
            if (Start) begin
               mode_d  = Mode;
               split_d = '0;
               state_d = LS2C;
            end
         end
         LS2C: begin
            // The final write holds J at DEPTH-1 so the index never wraps.
            if (c2 && j_q == LAST) begin
               split_d = split_q + SPLIT_ONE;
               state_d = DONE;
            end else begin
               if (c2) begin
                  j_d     = j_q + IDX_ONE;
                  split_d = split_q + SPLIT_ONE;
               end
               if (i_q == LAST) begin
                  i_d     = '0;
                  state_d = CBC;
               end else begin
                  i_d = i_q + IDX_ONE;
               end
            end
         end
         CBC: begin
            if (!c2 && j_q == LAST) begin
               state_d = DONE;
            end else begin
               if (!c2) begin
                  j_d = j_q + IDX_ONE;
               end
               if (i_q == LAST) begin
                  state_d = DONE;
               end else begin
                  i_d = i_q + IDX_ONE;
               end
            end
         end
         DONE: begin
            if (Ack) begin
               state_d = INI;
            end
         end
         default: begin
            state_d = INI;
         end
      endcase
   end

   assign Ns_of_J_Write = ((state_q == LS2C) && c2) || ((state_q == CBC) && !c2);
   assign I     = i_q;
   assign J     = j_q;
   assign Split = split_q;
   assign Qi    = (state_q == INI);
   assign Qls   = (state_q == LS2C);
   assign Qcb   = (state_q == CBC);
   assign Qd    = (state_q == DONE);
   assign Done  = Qd;

endmodule
`default_nettype wire

// File: tb/tb_copy_array_partition_param.sv
`default_nettype none
// tb_copy_array_partition_param: directed and random partition runs on a 10x4 and a 16x8 instance.
module tb_copy_array_partition_param;

   logic       clk = 1'b0;
   logic       rst, start, ack, mode, sel, clr;
   int         checks = 0;
   int         errors = 0;

   logic [7:0] m_a[16], m_b[16], n_a[16], n_b[16], mem[16], fill[16];
   logic [3:0] ms_a;
   logic [7:0] ms_b;
   logic [3:0] i_a, j_a, i_b, j_b;
   logic [4:0] split_a, split_b;
   logic       wr_a, done_a, qi_a, qls_a, qcb_a, qd_a;
   logic       wr_b, done_b, qi_b, qls_b, qcb_b, qd_b;
   logic       start_a, start_b, ack_a, ack_b;

   logic [3:0] w_i, w_j;
   logic [4:0] w_split;
   logic       w_wr, w_done, w_qi, w_qls, w_qcb, w_qd;

   always #5 clk = ~clk;

   assign ms_a    = m_a[i_a][3:0];
   assign ms_b    = m_b[i_b];
   assign start_a = start & ~sel;
   assign start_b = start & sel;
   assign ack_a   = ack & ~sel;
   assign ack_b   = ack & sel;

   assign w_i     = sel ? i_b : i_a;
   assign w_j     = sel ? j_b : j_a;
   assign w_split = sel ? split_b : split_a;
   assign w_wr    = sel ? wr_b : wr_a;
   assign w_done  = sel ? done_b : done_a;
   assign w_qi    = sel ? qi_b : qi_a;
   assign w_qls   = sel ? qls_b : qls_a;
   assign w_qcb   = sel ? qcb_b : qcb_a;
   assign w_qd    = sel ? qd_b : qd_a;

   copy_array_partition_param #(.DW(4), .DEPTH(10), .AW(4)) u_dut_a (
      .Clk(clk), .Reset(rst), .Start(start_a), .Ack(ack_a), .Mode(mode), .Ms_of_I(ms_a),
      .I(i_a), .J(j_a), .Ns_of_J_Write(wr_a), .Split(split_a), .Done(done_a),
      .Qi(qi_a), .Qls(qls_a), .Qcb(qcb_a), .Qd(qd_a));

   copy_array_partition_param #(.DW(8), .DEPTH(16), .AW(4)) u_dut_b (
      .Clk(clk), .Reset(rst), .Start(start_b), .Ack(ack_b), .Mode(mode), .Ms_of_I(ms_b),
      .I(i_b), .J(j_b), .Ns_of_J_Write(wr_b), .Split(split_b), .Done(done_b),
      .Qi(qi_b), .Qls(qls_b), .Qcb(qcb_b), .Qd(qd_b));

   // Memory N of each instance, written at the clock edge from the strobe.
   always @(posedge clk) begin
      if (clr) begin
         for (int k = 0; k < 16; k++) begin
            n_a[k] <= fill[k];
            n_b[k] <= fill[k];
         end
      end else begin
         if (wr_a) n_a[j_a] <= {4'b0000, ms_a};
         if (wr_b) n_b[j_b] <= ms_b;
      end
   end

   // One complete run: load M, start, observe to DONE, compare with the stable partition.
   task automatic run(input bit s, input int depth, input int dw, input bit md,
                      input bit disturb, input string name);
      int   exp_n[$];
      int   exp_split, last_c1, exp_cycles, cycles, writes;
      bit   range_bad, finished, c2;
      logic [7:0] got;
      logic [4:0] split_hold;
      exp_n = {};
      exp_split = 0;
      last_c1 = -1;
      for (int k = 0; k < depth; k++) begin
         c2 = mem[k][dw-1] ^ md;
         if (c2) begin
            exp_n.push_back(int'(mem[k]));
            exp_split++;
         end else begin
            last_c1 = k;
         end
      end
      for (int k = 0; k < depth; k++) begin
         if (!(mem[k][dw-1] ^ md)) exp_n.push_back(int'(mem[k]));
      end
      exp_cycles = (exp_split == depth) ? depth : depth + last_c1 + 1;

      @(negedge clk);
      sel = s;
      for (int k = 0; k < 16; k++) begin
         if (s) m_b[k] = mem[k];
         else   m_a[k] = mem[k];
         fill[k] = (k < depth) ? ~(8'(exp_n[k])) : 8'h00;
      end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      mode = md;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      mode = 1'($urandom_range(0, 1));

      checks++;
      if (w_qls !== 1'b1 || w_split !== 5'd0) begin
         errors++;
         $display("FAIL %s start: Qls=%b Split=%0d, required Qls=1 Split=0", name, w_qls, w_split);
      end

      cycles = 0;
      writes = 0;
      range_bad = 1'b0;
      finished = 1'b0;
      for (int t = 0; t < 100; t++) begin
         if (w_done === 1'b1) begin
            finished = 1'b1;
            break;
         end
         if (w_qls || w_qcb) cycles++;
         if (w_wr) writes++;
         if (int'(w_i) > depth - 1 || int'(w_j) > depth - 1) range_bad = 1'b1;
         start = disturb && (t == 2);
         ack   = disturb && (t == 3);
         @(negedge clk);
         start = 1'b0;
         ack   = 1'b0;
      end

      checks++;
      if (!finished) begin
         errors++;
         $display("FAIL %s timeout: Done=%b, required 1 within 100 cycles", name, w_done);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         return;
      end
      checks++;
      if (w_split !== 5'(exp_split)) begin
         errors++;
         $display("FAIL %s split: got %0d, required %0d", name, w_split, exp_split);
      end
      checks++;
      if (cycles != exp_cycles) begin
         errors++;
         $display("FAIL %s cycles: got %0d, required %0d", name, cycles, exp_cycles);
      end
      checks++;
      if (writes != depth || range_bad) begin
         errors++;
         $display("FAIL %s writes/range: got %0d writes range_bad=%b, required %0d writes range_bad=0",
                  name, writes, range_bad, depth);
      end
      for (int k = 0; k < depth; k++) begin
         got = s ? n_b[k] : n_a[k];
         checks++;
         if (got !== 8'(exp_n[k])) begin
            errors++;
            $display("FAIL %s N[%0d]: got %0h, required %0h", name, k, got, exp_n[k]);
         end
      end

      // Results stay valid in DONE until Ack.
      split_hold = w_split;
      @(negedge clk);
      checks++;
      if (w_done !== 1'b1 || w_qd !== 1'b1 || w_wr !== 1'b0 || w_split !== split_hold) begin
         errors++;
         $display("FAIL %s hold: Done=%b Qd=%b Wr=%b Split=%0d, required 1 1 0 %0d",
                  name, w_done, w_qd, w_wr, w_split, split_hold);
      end
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      checks++;
      if (w_qi !== 1'b1 || w_done !== 1'b0) begin
         errors++;
         $display("FAIL %s ack: Qi=%b Done=%b, required Qi=1 Done=0", name, w_qi, w_done);
      end
   endtask

   task automatic load(input int d[10]);
      for (int k = 0; k < 16; k++) mem[k] = (k < 10) ? 8'(d[k]) : 8'h00;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (qi_a !== 1'b1 || i_a !== 4'd0 || j_a !== 4'd0 || split_a !== 5'd0 || done_a !== 1'b0 ||
          wr_a !== 1'b0 || qi_b !== 1'b1 || split_b !== 5'd0 || done_b !== 1'b0) begin
         errors++;
         $display("FAIL reset: Qi=%b I=%0d J=%0d Split=%0d Done=%b Wr=%b, required 1 0 0 0 0 0",
                  qi_a, i_a, j_a, split_a, done_a, wr_a);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (qi_a !== 1'b1 || qls_a !== 1'b0) begin
         errors++;
         $display("FAIL idle: Qi=%b Qls=%b, required Qi=1 Qls=0", qi_a, qls_a);
      end
   endtask

   task automatic test_sorted_mode0();
      load('{1, 3, 5, 7, 8, 9, 10, 12, 14, 15});
      run(1'b0, 10, 4, 1'b0, 1'b0, "sorted_mode0");
   endtask

   task automatic test_all_chunk1();
      load('{0, 1, 2, 3, 4, 5, 6, 7, 7, 7});
      run(1'b0, 10, 4, 1'b0, 1'b0, "all_chunk1");
   endtask

   task automatic test_all_chunk2();
      load('{8, 8, 9, 10, 11, 12, 13, 14, 15, 15});
      run(1'b0, 10, 4, 1'b0, 1'b0, "all_chunk2");
   endtask

   task automatic test_mode1();
      load('{8, 11, 15, 0, 2, 3, 4, 5, 6, 7});
      run(1'b0, 10, 4, 1'b1, 1'b0, "mode1");
   endtask

   task automatic test_reset_mid_cbc();
      bit seen;
      load('{0, 1, 2, 3, 4, 5, 6, 7, 7, 7});
      @(negedge clk);
      sel = 1'b0;
      for (int k = 0; k < 16; k++) m_a[k] = mem[k];
      mode = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 40 && !seen; t++) begin
         @(negedge clk);
         if (qcb_a && i_a == 4'd3) seen = 1'b1;
      end
      checks++;
      if (!seen || wr_a !== 1'b1) begin
         errors++;
         $display("FAIL mid_cbc reach: seen=%b Wr=%b, required 1 1", seen, wr_a);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (qi_a !== 1'b1 || qcb_a !== 1'b0 || wr_a !== 1'b0 || i_a !== 4'd0 || j_a !== 4'd0 ||
          split_a !== 5'd0) begin
         errors++;
         $display("FAIL mid_cbc reset: Qi=%b Qcb=%b Wr=%b I=%0d J=%0d Split=%0d, required 1 0 0 0 0 0",
                  qi_a, qcb_a, wr_a, i_a, j_a, split_a);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_ignored_pulses();
      load('{1, 9, 3, 12, 5, 14, 7, 8, 0, 15});
      run(1'b0, 10, 4, 1'b0, 1'b1, "ignored_pulses");
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 16; k++) mem[k] = (k < 10) ? 8'($urandom_range(0, 15)) : 8'h00;
         run(1'b0, 10, 4, 1'(r), 1'b0, "back_to_back");
      end
   endtask

   task automatic test_param_sweep();
      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < 16; k++) mem[k] = 8'($urandom_range(0, 255));
         run(1'b1, 16, 8, 1'(r), r == 3, "sweep_16x8");
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      ack = 1'b0;
      mode = 1'b0;
      sel = 1'b0;
      clr = 1'b0;
      for (int k = 0; k < 16; k++) begin
         m_a[k] = 8'h00;
         m_b[k] = 8'h00;
         mem[k] = 8'h00;
         fill[k] = 8'h00;
      end
      test_reset();
      test_sorted_mode0();
      test_all_chunk1();
      test_all_chunk2();
      test_mode1();
      test_reset_mid_cbc();
      test_ignored_pulses();
      test_back_to_back();
      test_param_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
